// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// FSM states, opcode classes, ALU operation codes and small helpers.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OC_NONE   = 3'd0,
    OC_R      = 3'd1,
    OC_I      = 3'd2,
    OC_LOAD   = 3'd3,
    OC_STORE  = 3'd4,
    OC_BRANCH = 3'd5
  } op_class_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] CC_AND = 4'b0000;
  localparam logic [3:0] CC_OR  = 4'b0001;
  localparam logic [3:0] CC_ADD = 4'b0010;
  localparam logic [3:0] CC_XOR = 4'b0011;
  localparam logic [3:0] CC_SUB = 4'b0110;
  localparam logic [3:0] CC_SLT = 4'b0111;
  localparam logic [3:0] CC_SLL = 4'b1000;
  localparam logic [3:0] CC_SRL = 4'b1001;
  localparam logic [3:0] CC_SRA = 4'b1010;

  // Wide enough to hold the count value TIMEOUT_CYCLES itself.
  function automatic int wdog_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  // Branches with an unsupported funct3 are classed as illegal.
  function automatic op_class_e classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R:    return OC_R;
      OP_I:    return OC_I;
      OP_LW:   return OC_LOAD;
      OP_SW:   return OC_STORE;
      OP_BR:   return ((f3 == F3_BEQ) || (f3 == F3_BNE)) ? OC_BRANCH : OC_NONE;
      default: return OC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational mapping from (opcode class, funct3, funct7) to the ALU
// operation code. Only funct7[5] carries information for RV32I base ops.
module alu_decoder
  import multicycle_pkg::*;
(
  input  op_class_e   op_class_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [3:0]  alu_cc_o
);

  logic alt_sel;
  logic unused_funct7;

  assign alt_sel       = funct7_i[5];
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

  always_comb begin
    alu_cc_o = CC_ADD;
    case (op_class_i)
      OC_R, OC_I: begin
        case (funct3_i)
          3'b000:  alu_cc_o = ((op_class_i == OC_R) && alt_sel) ? CC_SUB : CC_ADD;
          3'b001:  alu_cc_o = CC_SLL;
          3'b010:  alu_cc_o = CC_SLT;
          3'b011:  alu_cc_o = CC_SLT;
          3'b100:  alu_cc_o = CC_XOR;
          // Arithmetic right shift is flagged by funct7[5] in both formats.
          3'b101:  alu_cc_o = alt_sel ? CC_SRA : CC_SRL;
          3'b110:  alu_cc_o = CC_OR;
          default: alu_cc_o = CC_AND;
        endcase
      end
      OC_BRANCH: alu_cc_o = CC_SUB;
      default:   alu_cc_o = CC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshake,
// memory watchdog, sticky illegal-instruction fault and retire counter.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [3:0]       alu_cc,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WD_W = wdog_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q;
  logic [2:0]       funct3_q;
  logic [6:0]       funct7_q;
  logic [WD_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             fault_q;

  op_class_e        dec_class;
  op_class_e        op_class_q;
  logic [3:0]       dec_cc;
  logic             mem_phase;
  logic             mem_wait;
  logic             timeout;
  logic             retire;

  assign dec_class  = classify(opcode, funct3);
  assign op_class_q = classify(opcode_q, funct3_q);

  alu_decoder u_alu_decoder (
    .op_class_i (op_class_q),
    .funct3_i   (funct3_q),
    .funct7_i   (funct7_q),
    .alu_cc_o   (dec_cc)
  );

  // A request that is still unanswered on its TIMEOUT_CYCLES-th cycle
  // faults; a ready in that same cycle completes normally.
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_wait  = mem_phase && !mem_ready;
  assign timeout   = mem_wait && (wait_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    wait_d  = (mem_wait && !timeout) ? wait_q + WD_W'(1) : '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: state_d = (dec_class == OC_NONE) ? S_FAULT : S_EXEC;
      S_EXEC: begin
        case (op_class_q)
          OC_R, OC_I:         state_d = S_WB;
          OC_LOAD, OC_STORE:  state_d = S_MEM;
          OC_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:            state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_class_q == OC_STORE) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
        funct3_q <= funct3;
        funct7_q <= funct7;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state_d == S_FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src   = 1'b0;
    alu_cc    = 4'b0000;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        alu_src = (op_class_q == OC_I) || (op_class_q == OC_LOAD) || (op_class_q == OC_STORE);
        alu_cc  = dec_cc;
        if (op_class_q == OC_BRANCH) begin
          pc_src   = 1'b1;
          pc_write = (funct3_q == F3_BNE) ? !zero : zero;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class_q == OC_STORE);
        alu_cc  = CC_ADD;
        alu_src = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = (op_class_q == OC_LOAD);
      end
      default: ;
    endcase
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle control
// vectors; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_XOR = 4'b0011;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_SLL = 4'b1000;
  localparam logic [3:0] A_SRL = 4'b1001;
  localparam logic [3:0] A_SRA = 4'b1010;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
  logic [3:0] alu_cc;
  logic       reg_write, mem2reg, fault;
  logic [3:0] retired;

  multicycle_controller #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src   (alu_src),
    .alu_cc    (alu_cc),
    .reg_write (reg_write),
    .mem2reg   (mem2reg),
    .fault     (fault),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] ev;
    logic [3:0]  er;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [3:0] exp_ret;
  logic [6:0] ins_op;
  logic [2:0] ins_f3;
  logic [6:0] ins_f7;
  logic       ins_z;

  // {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_cc, reg_write, mem2reg, fault}
  function automatic logic [12:0] v(input bit req, we, irw, pcw, pcs, asrc,
                                    input logic [3:0] cc, input bit rw, m2r, flt);
    return {req, we, irw, pcw, pcs, asrc, cc, rw, m2r, flt};
  endfunction

  logic [12:0] V0, VF_W, VF_R, VFLT;
  logic [12:0] act_vec;
  assign act_vec = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
                    alu_cc, reg_write, mem2reg, fault};

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (act_vec !== mon_e.ev || retired !== mon_e.er) begin
        n_err++;
        $display("FAIL %s: ctl=%b retired=%0d, expected ctl=%b retired=%0d",
                 mon_e.tag, act_vec, retired, mon_e.ev, mon_e.er);
      end else begin
        $display("ok   %s: ctl=%b retired=%0d", mon_e.tag, act_vec, retired);
      end
    end
  end

  task automatic push(input string tag, input logic [12:0] ev);
    exp_t e;
    e.tag = tag;
    e.ev  = ev;
    e.er  = exp_ret;
    sb_q.push_back(e);
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z);
    ins_op = op; ins_f3 = f3; ins_f7 = f7; ins_z = z;
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [12:0] ev, input bit ret);
    @(posedge clk); #1;
    mem_ready = rdy;
    opcode = ins_op; funct3 = ins_f3; funct7 = ins_f7; zero = ins_z;
    push(tag, ev);
    if (ret) exp_ret = exp_ret + 4'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1; exp_ret = 4'd0;
    push("in_reset", V0);
    @(posedge clk); #1;
    push("in_reset", V0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    push("idle", V0);
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_fetch"}, 1'b1, VF_R, 1'b0);
    cyc({tag, "_decode"}, 1'b1, V0, 1'b0);
  endtask

  task automatic alu_ins(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input bit asrc, input logic [3:0] cc);
    set_ins(op, f3, f7, 1'b0);
    fetch_decode(tag);
    cyc({tag, "_exec"}, 1'b1, v(0,0,0,0,0,asrc,cc,0,0,0), 1'b0);
    cyc({tag, "_wb"}, 1'b1, v(0,0,0,0,0,0,4'b0000,1,0,0), 1'b1);
  endtask

  task automatic sw_ins(input string tag);
    set_ins(7'b0100011, 3'b010, 7'd0, 1'b0);
    fetch_decode(tag);
    cyc({tag, "_exec"}, 1'b0, v(0,0,0,0,0,1,A_ADD,0,0,0), 1'b0);
    cyc({tag, "_mem"}, 1'b1, v(1,1,0,0,0,1,A_ADD,0,0,0), 1'b1);
  endtask

  task automatic branch_ins(input string tag, input logic [2:0] f3, input logic z, input bit taken);
    set_ins(7'b1100011, f3, 7'd0, z);
    fetch_decode(tag);
    cyc({tag, "_exec"}, 1'b1, v(0,0,0,taken,1,0,A_SUB,0,0,0), 1'b1);
  endtask

  task automatic direct_chk(input string tag, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, act, req);
    end else begin
      $display("ok   %s: %b", tag, act);
    end
  endtask

  initial begin
    V0   = v(0,0,0,0,0,0,4'b0000,0,0,0);
    VF_W = v(1,0,0,0,0,0,4'b0000,0,0,0);
    VF_R = v(1,0,1,1,0,0,4'b0000,0,0,0);
    VFLT = v(0,0,0,0,0,0,4'b0000,0,0,1);
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0;
    exp_ret = 4'd0;
    set_ins(7'd0, 3'd0, 7'd0, 1'b0);

    do_reset();
    alu_ins("add",  7'b0110011, 3'b000, 7'b0000000, 1'b0, A_ADD);
    alu_ins("sub",  7'b0110011, 3'b000, 7'b0100000, 1'b0, A_SUB);
    alu_ins("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 1'b1, A_ADD);
    alu_ins("srai", 7'b0010011, 3'b101, 7'b0100000, 1'b1, A_SRA);
    alu_ins("srli", 7'b0010011, 3'b101, 7'b0000000, 1'b1, A_SRL);
    alu_ins("sll",  7'b0110011, 3'b001, 7'b0000000, 1'b0, A_SLL);
    alu_ins("slt",  7'b0110011, 3'b010, 7'b0000000, 1'b0, A_SLT);
    alu_ins("xor",  7'b0110011, 3'b100, 7'b0000000, 1'b0, A_XOR);
    alu_ins("or",   7'b0110011, 3'b110, 7'b0000000, 1'b0, A_OR);
    alu_ins("and",  7'b0110011, 3'b111, 7'b0000000, 1'b0, A_AND);
    alu_ins("sra",  7'b0110011, 3'b101, 7'b0100000, 1'b0, A_SRA);

    // LW with three wait cycles in MEM
    set_ins(7'b0000011, 3'b010, 7'd0, 1'b0);
    fetch_decode("lw");
    cyc("lw_exec", 1'b1, v(0,0,0,0,0,1,A_ADD,0,0,0), 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, v(1,0,0,0,0,1,A_ADD,0,0,0), 1'b0);
    cyc("lw_mem_rdy", 1'b1, v(1,0,0,0,0,1,A_ADD,0,0,0), 1'b0);
    cyc("lw_wb", 1'b0, v(0,0,0,0,0,0,4'b0000,1,1,0), 1'b1);

    // SW with two wait cycles in FETCH
    set_ins(7'b0100011, 3'b010, 7'd0, 1'b0);
    cyc("sw_fetch_wait", 1'b0, VF_W, 1'b0);
    cyc("sw_fetch_wait", 1'b0, VF_W, 1'b0);
    sw_ins("sw");

    branch_ins("beq_z1", 3'b000, 1'b1, 1'b1);
    branch_ins("beq_z0", 3'b000, 1'b0, 1'b0);
    branch_ins("bne_z0", 3'b001, 1'b0, 1'b1);
    branch_ins("bne_z1", 3'b001, 1'b1, 1'b0);

    // Illegal opcode: sticky fault, retired frozen
    set_ins(7'b1111111, 3'b000, 7'd0, 1'b0);
    fetch_decode("illegal");
    for (int i = 0; i < 3; i++) cyc("illegal_fault", 1'b1, VFLT, 1'b0);
    do_reset();

    // Unsupported branch funct3
    set_ins(7'b1100011, 3'b010, 7'd0, 1'b0);
    fetch_decode("bad_br");
    cyc("bad_br_fault", 1'b1, VFLT, 1'b0);
    do_reset();

    // Watchdog expires after 15 unanswered FETCH cycles
    set_ins(7'b0110011, 3'b000, 7'd0, 1'b0);
    for (int i = 0; i < 15; i++) cyc("wd_fetch_wait", 1'b0, VF_W, 1'b0);
    cyc("wd_fault", 1'b1, VFLT, 1'b0);
    cyc("wd_fault", 1'b1, VFLT, 1'b0);
    do_reset();

    // Ready on the 15th cycle wins over the watchdog
    for (int i = 0; i < 14; i++) cyc("wd15_fetch_wait", 1'b0, VF_W, 1'b0);
    cyc("wd15_fetch_rdy", 1'b1, VF_R, 1'b0);
    cyc("wd15_decode", 1'b0, V0, 1'b0);
    cyc("wd15_exec", 1'b0, v(0,0,0,0,0,0,A_ADD,0,0,0), 1'b0);
    cyc("wd15_wb", 1'b0, v(0,0,0,0,0,0,4'b0000,1,0,0), 1'b1);
    do_reset();

    // 17 stores wrap the 4-bit retire counter to 1
    for (int i = 0; i < 17; i++) sw_ins("sw_wrap");
    set_ins(7'b0100011, 3'b010, 7'd0, 1'b0);
    fetch_decode("sw_rst");
    cyc("sw_rst_exec", 1'b0, v(0,0,0,0,0,1,A_ADD,0,0,0), 1'b0);
    cyc("sw_rst_mem_stall", 1'b0, v(1,1,0,0,0,1,A_ADD,0,0,0), 1'b0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    direct_chk("async_reset_mid_mem", {mem_req, mem_we, retired}, 6'b000000);
    do_reset();

    alu_ins("post_rst_add", 7'b0110011, 3'b000, 7'd0, 1'b0, A_ADD);
    cyc("post_rst_fetch", 1'b0, VF_W, 1'b0);

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
